fc_argmax_reader: RTL

//   Consumer side of the fully-connected output interface: waits for scores_ready, then

---
 rtl/fc_argmax_reader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fc_argmax_reader.sv
// Argmax reader for the final FC layer: scans OC signed Q8.8 scores one per cycle,
// reports winner index, score, margin to runner-up and a confidence flag under valid/ack.
module fc_argmax_reader #(
  parameter int unsigned OC         = 10,
  parameter int unsigned IDXW       = $clog2(OC),
  parameter int unsigned MIN_MARGIN = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scores_ready,
  input  logic [16*OC-1:0]     scores,
  input  logic                 result_ack,
  output logic                 result_valid,
  output logic [IDXW-1:0]      class_idx,
  output logic [15:0]          best_score,
  output logic [16:0]          margin,
  output logic                 confident,
  output logic                 busy,
  output logic                 scan_abort
);

  localparam int unsigned SW = 16;
  localparam int unsigned MW = 17;
  // cnt must reach OC: the extra SCAN cycle registers the result
  localparam int unsigned CW = $clog2(OC + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    DONE     = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic signed [SW-1:0]  best;
  logic signed [SW-1:0]  second;
  logic [IDXW-1:0]       best_idx;

  logic signed [SW-1:0]  cur_c;
  logic signed [MW-1:0]  diff_c;
  logic [MW-1:0]         margin_c;
  logic                  confident_c;

  // Select the score currently addressed by cnt
  always_comb begin
    cur_c = '0;
    for (int i = 0; i < int'(OC); i++) begin
      if (cnt == CW'(i)) cur_c = scores[SW*i +: SW];
    end
  end

  always_comb begin
    diff_c      = {best[SW-1], best} - {second[SW-1], second};
    margin_c    = MW'(diff_c);
    confident_c = (margin_c >= MW'(MIN_MARGIN));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      best         <= '0;
      second       <= '0;
      best_idx     <= '0;
      result_valid <= 1'b0;
      class_idx    <= '0;
      best_score   <= '0;
      margin       <= '0;
      confident    <= 1'b0;
      busy         <= 1'b0;
      scan_abort   <= 1'b0;
    end else begin
      scan_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (scores_ready) begin
            state    <= SCAN;
            cnt      <= '0;
            best     <= 16'sh8000;
            second   <= 16'sh8000;
            best_idx <= '0;
            busy     <= 1'b1;
          end
        end

        SCAN: begin
          if (!scores_ready) begin
            state      <= IDLE;
            busy       <= 1'b0;
            scan_abort <= 1'b1;
          end else if (cnt == CW'(OC)) begin
            class_idx    <= best_idx;
            best_score   <= best;
            margin       <= margin_c;
            confident    <= confident_c;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= DONE;
          end else begin
            // Strict compares keep the lowest index on ties
            if (cur_c > best) begin
              second   <= best;
              best     <= cur_c;
              best_idx <= IDXW'(cnt);
            end else if (cur_c > second) begin
              second <= cur_c;
            end
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            state        <= scores_ready ? WAIT_LOW : IDLE;
          end
        end

        WAIT_LOW: begin
          if (!scores_ready) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
